// File: rtl/tjpu_stream_router.sv
// tjpu_stream_router: per-packet demux of one inbound stream to compute engines,
// and an arbitrated merge of engine results through a 2-entry registered skid buffer
module tjpu_stream_router #(
    parameter int DATA_W      = 128,
    parameter int NUM_ENGINES = 4,
    parameter int DEST_W      = 3,
    parameter int CNT_W       = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_start,
    input  logic [DEST_W-1:0]             cfg_dest,
    input  logic                          cfg_mode,
    input  logic [NUM_ENGINES-1:0]        cfg_suppress,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    input  logic                          s_last,
    output logic                          s_ready,
    output logic [DATA_W-1:0]             eng_in_data,
    output logic [NUM_ENGINES-1:0]        eng_in_valid,
    output logic                          eng_in_last,
    input  logic [NUM_ENGINES-1:0]        eng_in_ready,
    input  logic [NUM_ENGINES*DATA_W-1:0] eng_out_data,
    input  logic [NUM_ENGINES-1:0]        eng_out_valid,
    input  logic [NUM_ENGINES-1:0]        eng_out_last,
    output logic [NUM_ENGINES-1:0]        eng_out_ready,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_valid,
    output logic                          m_last,
    input  logic                          m_ready,
    output logic                          busy,
    output logic                          err_dest,
    output logic [CNT_W-1:0]              in_beat_cnt,
    output logic [CNT_W-1:0]              out_beat_cnt
);
    localparam int IW = $clog2(NUM_ENGINES);
    typedef enum logic [1:0] {IDLE, ROUTE, DROP} in_state_t;
    typedef enum logic {ARB, GRANT} out_state_t;
    in_state_t in_state, in_next;
    out_state_t out_state, out_next;
    logic [DEST_W-1:0] dest_q;
    logic mode_q, start, dest_ok, push, push_last, pop, rr_hit, grant_ok;
    logic [NUM_ENGINES-1:0] supp_q, dest_oh, g_oh, cand, rot;
    logic [IW-1:0] g_q, g_sel, rr_sel, rr_ptr;
    logic [DATA_W-1:0] mem [2];
    logic [1:0] mem_last, cnt;
    logic wr_q, rd_q;
    logic [DATA_W-1:0] push_data;

    for (genvar i = 0; i < NUM_ENGINES; i++) begin : g_onehot
        assign dest_oh[i] = dest_q == DEST_W'(i);
        assign g_oh[i]    = g_q == IW'(i);
    end

    assign start       = cfg_start && in_state == IDLE;
    assign dest_ok     = 32'(cfg_dest) < NUM_ENGINES;
    assign eng_in_data = in_state == ROUTE ? s_data : '0;
    assign eng_in_last = in_state == ROUTE && s_last;
    assign cand        = eng_out_valid & ~supp_q;
    assign push        = out_state == GRANT && !cnt[1] && |(eng_out_valid & g_oh);
    assign push_last   = |(eng_out_last & g_oh);
    assign push_data   = eng_out_data[g_q*DATA_W +: DATA_W];
    assign m_valid     = cnt != 2'd0;
    assign m_data      = m_valid ? mem[rd_q] : '0;
    assign m_last      = m_valid && mem_last[rd_q];
    assign pop         = m_valid && m_ready;
    assign busy        = in_state != IDLE || out_state == GRANT || m_valid;

    always_comb begin
        in_next = in_state;
        s_ready = 1'b0;
        eng_in_valid = '0;
        if (in_state == IDLE && cfg_start) in_next = dest_ok ? ROUTE : DROP;
        if (in_state == ROUTE) begin
            s_ready = |(eng_in_ready & dest_oh);
            eng_in_valid = s_valid ? dest_oh : '0;
        end
        if (in_state == DROP) s_ready = 1'b1;
        if (in_state != IDLE && s_valid && s_ready && s_last) in_next = IDLE;
    end

    // Rotate candidates so bit 0 is rr_ptr; the lowest set bit is the next round-robin winner
    always_comb begin
        rot = NUM_ENGINES'({cand, cand} >> rr_ptr);
        rr_hit = 1'b0;
        rr_sel = '0;
        for (int k = NUM_ENGINES - 1; k >= 0; k--)
            if (rot[k]) begin
                rr_hit = 1'b1;
                rr_sel = IW'((int'(rr_ptr) + k) % NUM_ENGINES);
            end
        grant_ok = mode_q ? rr_hit : |(cand & dest_oh);
        g_sel = mode_q ? rr_sel : IW'(dest_q);
        out_next = out_state;
        eng_out_ready = '0;
        if (out_state == ARB && grant_ok) out_next = GRANT;
        if (out_state == GRANT) begin
            eng_out_ready = cnt[1] ? '0 : g_oh;
            if (push && push_last) out_next = ARB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_state     <= IDLE;
            out_state    <= ARB;
            dest_q       <= '0;
            mode_q       <= 1'b0;
            supp_q       <= '0;
            g_q          <= '0;
            rr_ptr       <= '0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            cnt          <= '0;
            err_dest     <= 1'b0;
            in_beat_cnt  <= '0;
            out_beat_cnt <= '0;
        end else begin
            in_state  <= in_next;
            out_state <= out_next;
            err_dest  <= start && !dest_ok;
            if (start) begin
                dest_q <= cfg_dest;
                mode_q <= cfg_mode;
                supp_q <= cfg_suppress;
            end
            if (out_state == ARB && grant_ok) g_q <= g_sel;
            if (push && push_last && mode_q) rr_ptr <= IW'((int'(g_q) + 1) % NUM_ENGINES);
            if (push) wr_q <= ~wr_q;
            if (pop) rd_q <= ~rd_q;
            cnt <= cnt + 2'(push) - 2'(pop);
            in_beat_cnt <= start ? '0 :
                (s_valid && s_ready && !(&in_beat_cnt)) ? in_beat_cnt + CNT_W'(1) : in_beat_cnt;
            out_beat_cnt <= start ? '0 :
                (pop && !(&out_beat_cnt)) ? out_beat_cnt + CNT_W'(1) : out_beat_cnt;
        end
    end

    // Payload storage needs no reset: m_data is masked while the buffer is empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q]      <= push_data;
            mem_last[wr_q] <= push_last;
        end
    end
endmodule

// File: tb/tb_tjpu_stream_router.sv
// tb_tjpu_stream_router: table-driven routing vectors plus scoreboarded packet sequences
module tb_tjpu_stream_router;
    localparam int DW = 128, NE = 4, DSW = 3, CW = 24;
    logic clk = 1'b0, rst;
    logic cfg_start, cfg_mode;
    logic [DSW-1:0] cfg_dest;
    logic [NE-1:0] cfg_suppress;
    logic [DW-1:0] s_data, eng_in_data, m_data;
    logic s_valid, s_last, s_ready, eng_in_last, m_valid, m_last, m_ready, busy, err_dest;
    logic [NE-1:0] eng_in_valid, eng_in_ready, eng_out_valid, eng_out_last, eng_out_ready;
    logic [NE*DW-1:0] eng_out_data;
    logic [CW-1:0] in_beat_cnt, out_beat_cnt;

    always #5 clk = ~clk;

    tjpu_stream_router #(.DATA_W(DW), .NUM_ENGINES(NE), .DEST_W(DSW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_dest(cfg_dest), .cfg_mode(cfg_mode),
        .cfg_suppress(cfg_suppress), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .eng_in_data(eng_in_data), .eng_in_valid(eng_in_valid),
        .eng_in_last(eng_in_last), .eng_in_ready(eng_in_ready), .eng_out_data(eng_out_data),
        .eng_out_valid(eng_out_valid), .eng_out_last(eng_out_last), .eng_out_ready(eng_out_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .busy(busy),
        .err_dest(err_dest), .in_beat_cnt(in_beat_cnt), .out_beat_cnt(out_beat_cnt)
    );

    typedef struct {int eng; logic [DW-1:0] data; logic last;} in_t;
    typedef struct {logic [DW-1:0] data; logic last;} out_t;
    typedef struct {int dest; bit sv; logic [NE-1:0] rdy; logic [NE-1:0] ev; bit esr; bit eerr;} vec_t;

    in_t in_q[$];
    out_t out_q[$];
    vec_t tbl[8];
    int total = 0, bad = 0, tag = 0;
    int src_left[NE], src_pk[NE], src_b[NE];
    int acc_stall, pops_win, rdy0_seen;
    logic pmv = 1'b0, pmr = 1'b0;
    logic [DW-1:0] pdata;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_val(input int e, input int p, input int b);
        return {32'(e), 32'(p), 32'(b), 32'hC0DE_0000};
    endfunction

    // Scoreboard: engine-side and outbound handshakes are compared against queued expectations
    always @(negedge clk) begin : monitor
        in_t e;
        out_t o;
        if (rst) pmv = 1'b0;
        else begin
            for (int i = 0; i < NE; i++)
                if (eng_in_valid[i] && eng_in_ready[i]) begin
                    if (in_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL in_unexpected: beat on engine %0d with empty queue", i);
                    end else begin
                        e = in_q.pop_front();
                        chk("in_eng", i, e.eng);
                        chk("in_data", eng_in_data, e.data);
                        chk("in_last", eng_in_last, e.last);
                    end
                end
            if (pmv && !pmr) begin
                chk("m_hold_valid", m_valid, 1'b1);
                chk("m_hold_data", m_data, pdata);
            end
            if (m_valid && m_ready) begin
                if (out_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL out_unexpected: data %0h with empty queue", m_data);
                end else begin
                    o = out_q.pop_front();
                    chk("out_data", m_data, o.data);
                    chk("out_last", m_last, o.last);
                end
            end
            pmv = m_valid; pmr = m_ready; pdata = m_data;
        end
    end

    task automatic do_reset();
        rst = 1'b1; cfg_start = 0; cfg_dest = '0; cfg_mode = 0; cfg_suppress = '0;
        s_valid = 0; s_last = 0; s_data = '0; eng_in_ready = '0;
        eng_out_valid = '0; eng_out_last = '0; eng_out_data = '0; m_ready = 0;
        for (int i = 0; i < NE; i++) begin src_left[i] = 0; src_pk[i] = 0; src_b[i] = 0; end
        in_q.delete(); out_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cfg(input int dest, input bit mode, input logic [NE-1:0] sup);
        cfg_dest = DSW'(dest); cfg_mode = mode; cfg_suppress = sup; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic send_pkt(input int eng, input int n, input bit tog);
        int b = 0, cyc = 0;
        logic hs;
        tag++;
        if (eng >= 0)
            for (int k = 0; k < n; k++) in_q.push_back('{eng, beat_val(9, tag, k), k == n - 1});
        while (b < n && cyc < 200) begin
            s_valid = 1'b1; s_data = beat_val(9, tag, b); s_last = b == n - 1;
            eng_in_ready = '1;
            if (tog && cyc % 2 == 1) eng_in_ready[0] = 1'b0;
            @(negedge clk);
            hs = s_ready;
            @(posedge clk); #1;
            if (hs) b++;
            cyc++;
        end
        s_valid = 0; s_last = 0;
        if (b < n) begin
            total++; bad++;
            $display("FAIL send_timeout: sent %0d of %0d beats", b, n);
        end
    endtask

    task automatic push_pkt(input int e, input int p);
        for (int b = 0; b < 3; b++) out_q.push_back('{beat_val(e, p, b), b == 2});
    endtask

    task automatic run_out(input int cycles, input int stall);
        acc_stall = 0; pops_win = 0; rdy0_seen = 0;
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < NE; i++) begin
                eng_out_valid[i] = src_left[i] > 0;
                eng_out_last[i] = src_b[i] == 2;
                eng_out_data[i*DW +: DW] = beat_val(i, src_pk[i], src_b[i]);
            end
            m_ready = c >= stall;
            @(negedge clk);
            if (eng_out_ready[0]) rdy0_seen++;
            if (m_valid && m_ready && c < stall + 3) pops_win++;
            for (int i = 0; i < NE; i++)
                if (eng_out_valid[i] && eng_out_ready[i]) begin
                    if (c < stall) acc_stall++;
                    if (src_b[i] == 2) begin src_b[i] = 0; src_pk[i]++; src_left[i]--; end
                    else src_b[i]++;
                end
            @(posedge clk); #1;
        end
        eng_out_valid = '0; m_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 1, 4'b0001, 4'b0001, 1, 0};
        tbl[1] = '{0, 1, 4'b1110, 4'b0001, 0, 0};
        tbl[2] = '{2, 1, 4'b0100, 4'b0100, 1, 0};
        tbl[3] = '{3, 0, 4'b1111, 4'b0000, 1, 0};
        tbl[4] = '{1, 1, 4'b0000, 4'b0010, 0, 0};
        tbl[5] = '{5, 1, 4'b0000, 4'b0000, 1, 1};
        tbl[6] = '{7, 0, 4'b0000, 4'b0000, 1, 1};
        tbl[7] = '{3, 1, 4'b1000, 4'b1000, 1, 0};

        do_reset();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_dest, 0);
        chk("rst_in_cnt", in_beat_cnt, 0);
        chk("rst_out_cnt", out_beat_cnt, 0);
        chk("rst_eng_in_valid", eng_in_valid, 0);
        chk("rst_eng_out_ready", eng_out_ready, 0);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            cfg(tbl[v].dest, 0, '0);
            chk("tbl_err", err_dest, tbl[v].eerr);
            s_valid = tbl[v].sv; eng_in_ready = tbl[v].rdy; s_last = 0;
            #1;
            chk("tbl_eng_in_valid", eng_in_valid, tbl[v].ev);
            chk("tbl_s_ready", s_ready, tbl[v].esr);
            s_valid = 0; eng_in_ready = '0;
        end

        do_reset();
        cfg(0, 0, '0);
        chk("route_err", err_dest, 0);
        send_pkt(0, 8, 1);
        chk("route_cnt", in_beat_cnt, 8);
        chk("route_idle_ready", s_ready, 0);
        chk("route_idle_busy", busy, 0);
        chk("route_q_empty", in_q.size(), 0);

        cfg(5, 0, '0);
        chk("drop_err_pulse", err_dest, 1);
        @(posedge clk); #1;
        chk("drop_err_clear", err_dest, 0);
        send_pkt(-1, 4, 0);
        chk("drop_cnt", in_beat_cnt, 4);
        chk("drop_idle_ready", s_ready, 0);

        do_reset();
        cfg(0, 1, '0);
        src_left[0] = 2; src_left[3] = 2;
        push_pkt(0, 0); push_pkt(3, 0); push_pkt(0, 1); push_pkt(3, 1);
        run_out(40, 0);
        chk("rr_q_empty", out_q.size(), 0);
        chk("rr_out_cnt", out_beat_cnt, 12);

        do_reset();
        cfg(0, 1, 4'b0001);
        src_left[0] = 1; src_left[1] = 1;
        push_pkt(1, 0);
        run_out(20, 0);
        chk("sup_q_empty", out_q.size(), 0);
        chk("sup_ready0", rdy0_seen, 0);
        chk("sup_e0_left", src_left[0], 1);
        chk("sup_out_cnt", out_beat_cnt, 3);

        do_reset();
        cfg(2, 0, '0);
        src_left[2] = 2;
        push_pkt(2, 0); push_pkt(2, 1);
        run_out(30, 10);
        chk("bp_buffered", acc_stall, 2);
        chk("bp_throughput", pops_win, 3);
        chk("bp_q_empty", out_q.size(), 0);
        chk("bp_out_cnt", out_beat_cnt, 6);

        do_reset();
        cfg(1, 0, '0);
        eng_in_ready = '1;
        eng_out_valid[1] = 1'b1; eng_out_data[DW +: DW] = beat_val(1, 7, 0);
        tag++;
        for (int b = 0; b < 3; b++) begin
            in_q.push_back('{1, beat_val(9, tag, b), 1'b0});
            s_valid = 1; s_last = 0; s_data = beat_val(9, tag, b);
            @(posedge clk); #1;
        end
        chk("rm_pre_m_valid", m_valid, 1);
        chk("rm_pre_cnt", in_beat_cnt, 3);
        s_data = beat_val(9, tag, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rm_s_ready", s_ready, 0);
        chk("rm_eng_in_valid", eng_in_valid, 0);
        chk("rm_m_valid", m_valid, 0);
        chk("rm_eng_out_ready", eng_out_ready, 0);
        chk("rm_in_cnt", in_beat_cnt, 0);
        chk("rm_out_cnt", out_beat_cnt, 0);
        chk("rm_busy", busy, 0);
        rst = 1'b0; s_valid = 0; eng_out_valid = '0;
        chk("rm_q_empty", in_q.size(), 0);
        cfg(3, 0, '0);
        send_pkt(3, 4, 0);
        chk("rm_new_cnt", in_beat_cnt, 4);
        chk("rm_new_q_empty", in_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
